// File: rtl/cmd_pkg.sv
// cmd_pkg: shared constants for the DDR4 command decoder.
//   - bit positions of the one-hot `commands` vector
//   - A-bus bit positions (auto-precharge, burst chop, RAS/CAS/WE)
//   - {RAS,CAS,WE} command encodings seen when act_n is high
package cmd_pkg;

  localparam int NUM_CMDS  = 19;

  localparam int CMD_DES   = 0;
  localparam int CMD_NOP   = 1;
  localparam int CMD_ACT   = 2;
  localparam int CMD_RD    = 3;
  localparam int CMD_RDA   = 4;
  localparam int CMD_WR    = 5;
  localparam int CMD_WRA   = 6;
  localparam int CMD_PRE   = 7;
  localparam int CMD_PREA  = 8;
  localparam int CMD_REF   = 9;
  localparam int CMD_MRS   = 10;
  localparam int CMD_ZQCL  = 11;
  localparam int CMD_ZQCS  = 12;
  localparam int CMD_SRE   = 13;
  localparam int CMD_SRX   = 14;
  localparam int CMD_PDE   = 15;
  localparam int CMD_PDX   = 16;
  localparam int CMD_RFU   = 17;
  localparam int CMD_BURST = 18;

  // A-bus bit positions
  localparam int A_AP  = 10;  // auto-precharge / all-banks / ZQ long
  localparam int A_BC  = 12;  // burst chop
  localparam int A_WE  = 14;
  localparam int A_CAS = 15;
  localparam int A_RAS = 16;

  // {RAS_n, CAS_n, WE_n} as carried on A[16:14]
  typedef enum logic [2:0] {
    RCW_MRS = 3'b000,
    RCW_REF = 3'b001,
    RCW_PRE = 3'b010,
    RCW_RFU = 3'b011,
    RCW_WR  = 3'b100,
    RCW_RD  = 3'b101,
    RCW_ZQ  = 3'b110,
    RCW_NOP = 3'b111
  } rcw_e;

endpackage

// File: rtl/cmd_bank_state.sv
// cmd_bank_state: per-bank row latch and burst column sequencer.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   sel               this bank is addressed by the current bg/ba
//   act, rd, wr, pr   decoded (already validity-gated) command strobes
//   prea              precharge-all strobe, affects every bank
//   a                 address bus
//   row_id            row latched on ACT
//   col_id            current burst column
//   burst             burst in flight
//   rd_o_wr           1 while a write burst is in flight
module cmd_bank_state
  import cmd_pkg::*;
#(
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 act,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 pr,
  input  logic                 prea,
  input  logic [ADDRWIDTH-1:0] a,
  output logic [ADDRWIDTH-1:0] row_id,
  output logic [COLWIDTH-1:0]  col_id,
  output logic                 burst,
  output logic                 rd_o_wr
);

  localparam int CNTW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BL - 1);

  logic [CNTW-1:0] beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_id  <= '0;
      col_id  <= '0;
      burst   <= 1'b0;
      rd_o_wr <= 1'b0;
      beat    <= '0;
    end else begin
      if (act && sel) row_id <= a;

      // Precharge wins; a new RD/WR restarts any burst already in flight.
      if (prea || (pr && sel)) begin
        burst   <= 1'b0;
        rd_o_wr <= 1'b0;
        beat    <= '0;
      end else if ((rd || wr) && sel) begin
        col_id  <= a[COLWIDTH-1:0];
        burst   <= 1'b1;
        rd_o_wr <= wr;
        beat    <= '0;
      end else if (burst) begin
        if (beat == LAST_BEAT) begin
          // column holds its last value; bank returns to idle
          burst   <= 1'b0;
          rd_o_wr <= 1'b0;
        end else begin
          col_id <= col_id + 1'b1;
          beat   <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmd.sv
// cmd: DDR4 command decoder and per-bank address tracker.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cke, cs_n      clock enable, chip select (active low)
//   act_n          activate (active low); when high, A[16:14] = RAS/CAS/WE
//   bg, ba         bank group / bank address
//   A              address / command bus
//   RowId          row latched per bank on ACT
//   ColId          current burst column per bank
//   rd_o_wr        per bank: 1 = write burst, 0 = read/idle
//   commands       combinational one-hot decode of the current pins
module cmd
  import cmd_pkg::*;
#(
  parameter int ADDRWIDTH  = 17,
  parameter int COLWIDTH   = 10,
  parameter int BGWIDTH    = 2,
  parameter int BANKGROUPS = 2**BGWIDTH,
  parameter int BAWIDTH    = 2,
  parameter int BL         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] A,
  output logic [ADDRWIDTH-1:0] RowId   [BANKGROUPS][2**BAWIDTH],
  output logic [COLWIDTH-1:0]  ColId   [BANKGROUPS][2**BAWIDTH],
  output logic                 rd_o_wr [BANKGROUPS][2**BAWIDTH],
  output logic [NUM_CMDS-1:0]  commands
);

  localparam int BANKSPERGROUP = 2**BAWIDTH;

  logic cke_q;
  logic in_sr;
  logic valid;
  logic cmd_ok;
  logic ap;
  rcw_e rcw;
  logic ACT, RD, WR, PR, PREA;
  logic sre, srx;
  logic any_burst;
  logic Burst [BANKGROUPS][BANKSPERGROUP];
  // burst chop is ignored: every burst runs the full BL beats
  logic unused_bc;

  assign unused_bc = A[A_BC];

  assign valid  = !cs_n && cke && cke_q;
  assign cmd_ok = valid && act_n;
  assign ap     = A[A_AP];
  assign rcw    = rcw_e'(A[A_RAS:A_WE]);

  assign ACT  = valid && !act_n;
  assign RD   = cmd_ok && (rcw == RCW_RD);
  assign WR   = cmd_ok && (rcw == RCW_WR);
  assign PR   = cmd_ok && (rcw == RCW_PRE);
  assign PREA = PR && ap;

  // Power-state transitions are keyed on the cke edge, not on valid.
  assign sre = !cs_n && act_n && (rcw == RCW_REF) && cke_q && !cke;
  assign srx = !cke_q && cke && in_sr;

  always_comb begin
    any_burst = 1'b0;
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        any_burst = any_burst | Burst[g][b];
      end
    end
  end

  always_comb begin
    commands            = '0;
    commands[CMD_DES]   = cs_n;
    commands[CMD_NOP]   = cmd_ok && (rcw == RCW_NOP);
    commands[CMD_ACT]   = ACT;
    commands[CMD_RD]    = RD && !ap;
    commands[CMD_RDA]   = RD && ap;
    commands[CMD_WR]    = WR && !ap;
    commands[CMD_WRA]   = WR && ap;
    commands[CMD_PRE]   = PR && !ap;
    commands[CMD_PREA]  = PREA;
    commands[CMD_REF]   = cmd_ok && (rcw == RCW_REF);
    commands[CMD_MRS]   = cmd_ok && (rcw == RCW_MRS);
    commands[CMD_ZQCL]  = cmd_ok && (rcw == RCW_ZQ) && ap;
    commands[CMD_ZQCS]  = cmd_ok && (rcw == RCW_ZQ) && !ap;
    commands[CMD_SRE]   = sre;
    commands[CMD_SRX]   = srx;
    commands[CMD_PDE]   = cke_q && !cke &&
                          (cs_n || (act_n && (rcw == RCW_NOP)));
    commands[CMD_PDX]   = !cke_q && cke && !in_sr;
    commands[CMD_RFU]   = cmd_ok && (rcw == RCW_RFU);
    commands[CMD_BURST] = any_burst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cke_q <= 1'b1;
      in_sr <= 1'b0;
    end else begin
      cke_q <= cke;
      if (sre)      in_sr <= 1'b1;
      else if (srx) in_sr <= 1'b0;
    end
  end

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
      cmd_bank_state #(
        .ADDRWIDTH (ADDRWIDTH),
        .COLWIDTH  (COLWIDTH),
        .BL        (BL)
      ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .sel     ((bg == BGWIDTH'(g)) && (ba == BAWIDTH'(b))),
        .act     (ACT),
        .rd      (RD),
        .wr      (WR),
        .pr      (PR),
        .prea    (PREA),
        .a       (A),
        .row_id  (RowId[g][b]),
        .col_id  (ColId[g][b]),
        .burst   (Burst[g][b]),
        .rd_o_wr (rd_o_wr[g][b])
      );
    end
  end

endmodule

// File: tb/tb_cmd.sv
module tb_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [16:0] A;
  logic [16:0] RowId   [4][4];
  logic [9:0]  ColId   [4][4];
  logic        rd_o_wr [4][4];
  logic [18:0] commands;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [16:0] row;
    logic [9:0]  col;
    bit          burst;
    bit          wr;
    bit          en_wr;
  } exp_t;

  exp_t sbq[$];

  cmd dut (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .cs_n     (cs_n),
    .act_n    (act_n),
    .bg       (bg),
    .ba       (ba),
    .A        (A),
    .RowId    (RowId),
    .ColId    (ColId),
    .rd_o_wr  (rd_o_wr),
    .commands (commands)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [16:0] row, input logic [9:0] col,
                              input bit burst, input bit wr, input bit en_wr);
    exp_t e;
    e.row = row; e.col = col; e.burst = burst; e.wr = wr; e.en_wr = en_wr;
    return e;
  endfunction

  task automatic pins(input logic c, input logic k, input logic an,
                      input logic [1:0] g, input logic [1:0] b, input logic [16:0] a);
    cs_n = c; cke = k; act_n = an; bg = g; ba = b; A = a;
  endtask

  // push the expected bank[0][1] state after the coming edge, then take the edge
  task automatic step(input exp_t e);
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_cmds(input string tag, input logic [18:0] exp);
    #1;
    check_val(tag, 32'(commands), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++) begin
        check_val({tag, "_row"},   32'(RowId[g][b]),   0);
        check_val({tag, "_col"},   32'(ColId[g][b]),   0);
        check_val({tag, "_burst"}, 32'(dut.Burst[g][b]), 0);
        check_val({tag, "_rdwr"},  32'(rd_o_wr[g][b]), 0);
      end
  endtask

  // scoreboard monitor: bank[0][1] state one edge after each driven command
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      check_val("sb_row",   32'(RowId[0][1]),     32'(e.row));
      check_val("sb_col",   32'(ColId[0][1]),     32'(e.col));
      check_val("sb_burst", 32'(dut.Burst[0][1]), 32'(e.burst));
      if (e.en_wr) check_val("sb_rdwr", 32'(rd_o_wr[0][1]), 32'(e.wr));
    end
  end

  localparam logic [16:0] NOP_A = 17'h1C000;

  initial begin
    reset = 1'b1;
    pins(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check_cmds("des_reset", 19'h1);
    check_all_zero("rst");

    // ACT bank[0][1], row 1
    pins(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 17'h00001);
    #1 check_val("act_strobe", 32'(dut.ACT), 1);
    check_cmds("cmd_act", 19'h1 << 2);
    step(mk(17'd1, 10'd0, 0, 0, 1));

    // WR col 8, eight beats then idle
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h10008);
    check_cmds("cmd_wr", 19'h1 << 5);
    step(mk(17'd1, 10'd8, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_nop_burst", (19'h1 << 1) | (19'h1 << 18));
    for (int k = 1; k < 8; k++) step(mk(17'd1, 10'(8 + k), 1, 1, 1));
    step(mk(17'd1, 10'd15, 0, 0, 0));
    check_cmds("cmd_nop_idle", 19'h1 << 1);

    // RD col 8
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h14008);
    check_cmds("cmd_rd", 19'h1 << 3);
    step(mk(17'd1, 10'd8, 1, 0, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    for (int k = 1; k < 8; k++) step(mk(17'd1, 10'(8 + k), 1, 0, 1));
    step(mk(17'd1, 10'd15, 0, 0, 1));

    // WR, two beats, then PRE bank[0][1]
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h10008);
    step(mk(17'd1, 10'd8, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    step(mk(17'd1, 10'd9, 1, 1, 1));
    step(mk(17'd1, 10'd10, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h08000);
    #1 check_val("pr_strobe", 32'(dut.PR), 1);
    check_cmds("cmd_pre", (19'h1 << 7) | (19'h1 << 18));
    step(mk(17'd1, 10'd10, 0, 0, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    step(mk(17'd1, 10'd10, 0, 0, 1));

    // WR bank[0][1], RD bank[1][2], then PREA clears both
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h10008);
    step(mk(17'd1, 10'd8, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 17'h14020);
    step(mk(17'd1, 10'd9, 1, 1, 1));
    check_val("b12_burst_on", 32'(dut.Burst[1][2]), 1);
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 17'h08400);
    check_cmds("cmd_prea", (19'h1 << 8) | (19'h1 << 18));
    step(mk(17'd1, 10'd9, 0, 0, 1));
    check_val("prea_b12_burst", 32'(dut.Burst[1][2]), 0);
    check_val("prea_b12_col",   32'(ColId[1][2]), 32'h20);
    check_val("prea_b12_row",   32'(RowId[1][2]), 0);

    // restart: WR then RD to the same bank mid-burst
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h10008);
    step(mk(17'd1, 10'd8, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    step(mk(17'd1, 10'd9, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h14040);
    step(mk(17'd1, 10'h40, 1, 0, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    for (int k = 1; k < 8; k++) step(mk(17'd1, 10'(10'h40 + k), 1, 0, 1));
    step(mk(17'd1, 10'h47, 0, 0, 1));

    // deselect: no state change
    pins(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 17'h10008);
    check_cmds("cmd_des", 19'h1);
    step(mk(17'd1, 10'h47, 0, 0, 1));

    // self-refresh entry/exit, then power-down entry/exit
    pins(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 17'h04000);
    check_cmds("cmd_sre", 19'h1 << 13);
    step(mk(17'd1, 10'h47, 0, 0, 1));
    pins(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_in_sr", 19'h1);
    step(mk(17'd1, 10'h47, 0, 0, 1));
    pins(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_srx", (19'h1 << 14) | 19'h1);
    step(mk(17'd1, 10'h47, 0, 0, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_nop_after_sr", 19'h1 << 1);
    step(mk(17'd1, 10'h47, 0, 0, 1));
    pins(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_pde", 19'h1 << 15);
    step(mk(17'd1, 10'h47, 0, 0, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    check_cmds("cmd_pdx", 19'h1 << 16);
    step(mk(17'd1, 10'h47, 0, 0, 1));

    // reset mid-burst
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 17'h10008);
    step(mk(17'd1, 10'd8, 1, 1, 1));
    pins(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, NOP_A);
    step(mk(17'd1, 10'd9, 1, 1, 1));
    reset = 1'b1;
    step(mk(17'd0, 10'd0, 0, 0, 1));
    reset = 1'b0;
    check_all_zero("midrst");
    check_cmds("cmd_after_rst", 19'h1 << 1);

    check_val("sb_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
